// File: rtl/if_fetch_unit_if.sv
// Instruction-memory read bus between the fetch unit (master) and the memory (slave).
interface if_fetch_unit_if;
  logic [31:0] IMem_Address;
  logic        IMem_Read;
  logic        IMem_Ready;
  logic [31:0] IMem_Data;

  modport master (
    output IMem_Address,
    output IMem_Read,
    input  IMem_Ready,
    input  IMem_Data
  );

  modport slave (
    input  IMem_Address,
    input  IMem_Read,
    output IMem_Ready,
    output IMem_Data
  );
endinterface

// File: rtl/if_fetch_unit.sv
// MIPS32 instruction-fetch front end: PC ownership, imem read handshake, delay-slot
// tracking, deferred branch redirects and exception redirect with in-flight read discard.
module if_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   ID_Stall,
  input  logic                   ID_IsBranch,
  input  logic                   ID_PCSrc,
  input  logic [31:0]            ID_BranchTarget,
  input  logic                   EX_Exception,
  input  logic [31:0]            Exc_Vector,
  if_fetch_unit_if.master        imem,
  output logic [31:0]            IF_Instruction,
  output logic [31:0]            IF_PC,
  output logic [31:0]            IF_PCAdd4,
  output logic                   IF_IsBDS,
  output logic                   IF_Stall
);

  typedef enum logic [1:0] {StFetch, StHold, StDiscard} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_buf_q, hold_buf_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic        bds_pend_q, bds_pend_d;
  logic [31:0] redir_target_q, redir_target_d;

  logic valid;
  logic handoff;
  logic branch_leaves_id;

  // Outputs; all request/valid signals are forced idle while reset is held.
  always_comb begin
    imem.IMem_Address = pc_q;
    imem.IMem_Read    = 1'b0;
    IF_Instruction    = '0;
    valid             = 1'b0;
    if (!reset) begin
      case (state_q)
        StFetch: begin
          imem.IMem_Read = 1'b1;
          if (imem.IMem_Ready) begin
            valid          = 1'b1;
            IF_Instruction = imem.IMem_Data;
          end
        end
        StHold: begin
          valid          = 1'b1;
          IF_Instruction = hold_buf_q;
        end
        StDiscard: imem.IMem_Read = 1'b1;
        default: ;
      endcase
    end
  end

  assign handoff          = valid & ~ID_Stall & ~EX_Exception;
  assign branch_leaves_id = ~ID_Stall & ~handoff;
  assign IF_Stall         = ~valid;
  assign IF_IsBDS         = valid & (ID_IsBranch | bds_pend_q);
  assign IF_PC            = pc_q;
  assign IF_PCAdd4        = pc_q + 32'd4;

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    hold_buf_d     = hold_buf_q;
    pend_valid_d   = pend_valid_q;
    pend_target_d  = pend_target_q;
    bds_pend_d     = bds_pend_q;
    redir_target_d = redir_target_q;

    if (EX_Exception) begin
      pend_valid_d = 1'b0;
      bds_pend_d   = 1'b0;
      hold_buf_d   = '0;
      case (state_q)
        StFetch: begin
          if (imem.IMem_Ready) begin
            pc_d = Exc_Vector;
          end else begin
            redir_target_d = Exc_Vector;
            state_d        = StDiscard;
          end
        end
        StHold: begin
          pc_d    = Exc_Vector;
          state_d = StFetch;
        end
        StDiscard: begin
          // The aborted read may complete in this same cycle; the newest vector wins.
          redir_target_d = Exc_Vector;
          if (imem.IMem_Ready) begin
            pc_d    = Exc_Vector;
            state_d = StFetch;
          end
        end
        default: state_d = StFetch;
      endcase
    end else begin
      case (state_q)
        StFetch: begin
          if (imem.IMem_Ready && ID_Stall) begin
            hold_buf_d = imem.IMem_Data;
            state_d    = StHold;
          end
        end
        StHold: begin
          if (handoff) state_d = StFetch;
        end
        StDiscard: begin
          if (imem.IMem_Ready) begin
            pc_d    = redir_target_q;
            state_d = StFetch;
          end
        end
        default: state_d = StFetch;
      endcase

      if (handoff) begin
        pend_valid_d = 1'b0;
        bds_pend_d   = 1'b0;
        if (ID_PCSrc && !ID_Stall) begin
          pc_d = ID_BranchTarget;
        end else if (pend_valid_q) begin
          pc_d = pend_target_q;
        end else begin
          pc_d = IF_PCAdd4;
        end
      end

      // Branch leaves ID before its delay slot is handed off: remember where to go.
      if (ID_PCSrc && branch_leaves_id) begin
        pend_valid_d  = 1'b1;
        pend_target_d = ID_BranchTarget;
      end
      if (ID_IsBranch && branch_leaves_id) bds_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= StFetch;
      pc_q           <= RESET_VECTOR;
      hold_buf_q     <= '0;
      pend_valid_q   <= 1'b0;
      pend_target_q  <= '0;
      bds_pend_q     <= 1'b0;
      redir_target_q <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      hold_buf_q     <= hold_buf_d;
      pend_valid_q   <= pend_valid_d;
      pend_target_q  <= pend_target_d;
      bds_pend_q     <= bds_pend_d;
      redir_target_q <= redir_target_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed, table-driven bench for if_fetch_unit; the bench plays both ID stage and imem.
module tb_if_fetch_unit;

  logic        clock;
  logic        reset;
  logic        ID_Stall;
  logic        ID_IsBranch;
  logic        ID_PCSrc;
  logic [31:0] ID_BranchTarget;
  logic        EX_Exception;
  logic [31:0] Exc_Vector;
  logic [31:0] IF_Instruction;
  logic [31:0] IF_PC;
  logic [31:0] IF_PCAdd4;
  logic        IF_IsBDS;
  logic        IF_Stall;

  if_fetch_unit_if imem_bus();

  if_fetch_unit dut (
    .clock           (clock),
    .reset           (reset),
    .ID_Stall        (ID_Stall),
    .ID_IsBranch     (ID_IsBranch),
    .ID_PCSrc        (ID_PCSrc),
    .ID_BranchTarget (ID_BranchTarget),
    .EX_Exception    (EX_Exception),
    .Exc_Vector      (Exc_Vector),
    .imem            (imem_bus),
    .IF_Instruction  (IF_Instruction),
    .IF_PC           (IF_PC),
    .IF_PCAdd4       (IF_PCAdd4),
    .IF_IsBDS        (IF_IsBDS),
    .IF_Stall        (IF_Stall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        stall;
    logic        br;
    logic        src;
    logic [31:0] tgt;
    logic        ex;
    logic [31:0] exv;
    logic        rdy;
    logic [31:0] data;
    logic        e_read;
    logic [31:0] e_addr;
    logic        e_stall;
    logic        e_bds;
    logic [31:0] e_instr;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(logic stall, logic br, logic src, logic [31:0] tgt, logic ex,
                              logic [31:0] exv, logic rdy, logic [31:0] data, logic e_read,
                              logic [31:0] e_addr, logic e_stall, logic e_bds,
                              logic [31:0] e_instr);
    vec_t v;
    v.stall = stall; v.br = br; v.src = src; v.tgt = tgt; v.ex = ex; v.exv = exv;
    v.rdy = rdy; v.data = data; v.e_read = e_read; v.e_addr = e_addr;
    v.e_stall = e_stall; v.e_bds = e_bds; v.e_instr = e_instr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    ID_Stall              = v.stall;
    ID_IsBranch           = v.br;
    ID_PCSrc              = v.src;
    ID_BranchTarget       = v.tgt;
    EX_Exception          = v.ex;
    Exc_Vector            = v.exv;
    imem_bus.IMem_Ready   = v.rdy;
    imem_bus.IMem_Data    = v.data;
  endtask

  initial begin
    logic [31:0] add4;
    reset = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Zero-wait memory, data = address
    vecs.push_back(mk(0,0,0,0,0,0, 1,32'hBFC00000, 1,32'hBFC00000,0,0,32'hBFC00000));
    vecs.push_back(mk(0,0,0,0,0,0, 1,32'hBFC00004, 1,32'hBFC00004,0,0,32'hBFC00004));
    vecs.push_back(mk(0,0,0,0,0,0, 1,32'hBFC00008, 1,32'hBFC00008,0,0,32'hBFC00008));
    // 2-wait fetch, ID stalled 3 cycles from the ready cycle
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,            1,32'hBFC0000C,1,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,            1,32'hBFC0000C,1,0,0));
    vecs.push_back(mk(1,0,0,0,0,0, 1,32'h11110001, 1,32'hBFC0000C,0,0,32'h11110001));
    vecs.push_back(mk(1,0,0,0,0,0, 0,32'hDEADBEEF, 0,32'hBFC0000C,0,0,32'h11110001));
    vecs.push_back(mk(1,0,0,0,0,0, 0,32'hDEADBEEF, 0,32'hBFC0000C,0,0,32'h11110001));
    vecs.push_back(mk(0,0,0,0,0,0, 0,32'hDEADBEEF, 0,32'hBFC0000C,0,0,32'h11110001));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,            1,32'hBFC00010,1,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 1,32'h22,       1,32'hBFC00010,0,0,32'h22));
    // Jump to 0x100 via exception, then taken branch with ready delay slot
    vecs.push_back(mk(0,0,0,0,1,32'h100, 1,32'h33, 1,32'hBFC00014,0,0,32'h33));
    vecs.push_back(mk(0,0,0,0,0,0, 1,32'h10000000, 1,32'h100,0,0,32'h10000000));
    vecs.push_back(mk(0,1,1,32'h400,0,0, 1,32'h104, 1,32'h104,0,1,32'h104));
    vecs.push_back(mk(0,0,0,0,0,0, 1,32'h400,      1,32'h400,0,0,32'h400));
    // Same branch, delay slot has 3 waits: deferred redirect
    vecs.push_back(mk(0,0,0,0,1,32'h100, 1,0,      1,32'h404,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 1,32'h100,      1,32'h100,0,0,32'h100));
    vecs.push_back(mk(0,1,1,32'h400,0,0, 0,0,      1,32'h104,1,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,            1,32'h104,1,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,            1,32'h104,1,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 1,32'h104,      1,32'h104,0,1,32'h104));
    vecs.push_back(mk(0,0,0,0,0,0, 1,32'h400,      1,32'h400,0,0,32'h400));
    // Exception during a 4-wait fetch at 0x200
    vecs.push_back(mk(0,0,0,0,1,32'h200, 1,0,      1,32'h404,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,            1,32'h200,1,0,0));
    vecs.push_back(mk(0,0,0,0,1,32'h80000180, 0,0, 1,32'h200,1,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,            1,32'h200,1,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,            1,32'h200,1,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 1,32'hBAD,      1,32'h200,1,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 1,32'h180,      1,32'h80000180,0,0,32'h180));
    // PC wrap, then exception beating ID_PCSrc / clearing a pending redirect
    vecs.push_back(mk(0,0,0,0,1,32'hFFFFFFFC, 1,0, 1,32'h80000184,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 1,32'hAAAA,     1,32'hFFFFFFFC,0,0,32'hAAAA));
    vecs.push_back(mk(0,0,0,0,0,0, 1,32'h5555,     1,32'h0,0,0,32'h5555));
    vecs.push_back(mk(0,0,1,32'h700,1,32'h80000180, 0,0, 1,32'h4,1,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 1,32'hBAD,      1,32'h4,1,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 1,32'h180,      1,32'h80000180,0,0,32'h180));
    vecs.push_back(mk(0,0,1,32'h700,0,0, 0,0,      1,32'h80000184,1,0,0));
    vecs.push_back(mk(0,0,0,0,1,32'h80000200, 0,0, 1,32'h80000184,1,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 1,32'hBAD,      1,32'h80000184,1,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 1,32'h200,      1,32'h80000200,0,0,32'h200));
    vecs.push_back(mk(0,0,0,0,0,0, 1,32'h0,        1,32'h80000204,0,0,0));
    // Exception while holding a captured word
    vecs.push_back(mk(1,0,0,0,0,0, 1,32'h77,       1,32'h80000208,0,0,32'h77));
    vecs.push_back(mk(1,0,0,0,1,32'h300, 0,0,      0,32'h80000208,0,0,32'h77));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,            1,32'h300,1,0,0));

    // Outputs while reset is held, with inputs trying to provoke activity
    @(negedge clock);
    ID_IsBranch         = 1'b1;
    imem_bus.IMem_Ready = 1'b1;
    imem_bus.IMem_Data  = 32'hFFFF0000;
    #1;
    chk("rst read",  {31'd0, imem_bus.IMem_Read}, 32'd0);
    chk("rst instr", IF_Instruction, 32'd0);
    chk("rst stall", {31'd0, IF_Stall}, 32'd1);
    chk("rst bds",   {31'd0, IF_IsBDS}, 32'd0);
    chk("rst pc",    IF_PC, 32'hBFC00000);
    chk("rst pc4",   IF_PCAdd4, 32'hBFC00004);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      if (i == 0) reset = 1'b0;
      drive(vecs[i]);
      #1;
      add4 = vecs[i].e_addr + 32'd4;
      chk($sformatf("row%0d read", i),  {31'd0, imem_bus.IMem_Read}, {31'd0, vecs[i].e_read});
      chk($sformatf("row%0d addr", i),  imem_bus.IMem_Address, vecs[i].e_addr);
      chk($sformatf("row%0d pc", i),    IF_PC, vecs[i].e_addr);
      chk($sformatf("row%0d pc4", i),   IF_PCAdd4, add4);
      chk($sformatf("row%0d stall", i), {31'd0, IF_Stall}, {31'd0, vecs[i].e_stall});
      chk($sformatf("row%0d bds", i),   {31'd0, IF_IsBDS}, {31'd0, vecs[i].e_bds});
      chk($sformatf("row%0d instr", i), IF_Instruction, vecs[i].e_instr);
    end

    // Reset asserted mid-read: read abandoned, PC back to the reset vector
    @(negedge clock);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    reset = 1'b1;
    #1;
    chk("midrst read",  {31'd0, imem_bus.IMem_Read}, 32'd0);
    chk("midrst pc",    IF_PC, 32'hBFC00000);
    chk("midrst stall", {31'd0, IF_Stall}, 32'd1);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("post rst read", {31'd0, imem_bus.IMem_Read}, 32'd1);
    chk("post rst addr", imem_bus.IMem_Address, 32'hBFC00000);
    @(negedge clock);
    imem_bus.IMem_Ready = 1'b1;
    imem_bus.IMem_Data  = 32'h0BAD0000;
    #1;
    chk("post rst instr", IF_Instruction, 32'h0BAD0000);
    chk("post rst stall", {31'd0, IF_Stall}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
